// File: rtl/stream_arb_mux.sv
// stream_arb_mux: registered N-to-1 valid/ready stream mux with
// round-robin, fixed-priority and forced-select arbitration.
//
// Parameters
//   WIDTH   data width per channel
//   NUM_IN  number of input channels (2..16)
//   SEL_W   channel index width, derived from NUM_IN
// Ports
//   Clk        clock, rising edge
//   Rst        synchronous active-high reset
//   in_data    packed channel data, channel i at [i*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel ready, one-hot or zero
//   mode       0 = round-robin, 1 = fixed priority (lowest index)
//   force_en   restrict eligibility to force_sel
//   force_sel  forced channel index
//   out_data   registered output beat
//   out_valid  output beat present
//   out_ready  downstream accepts beat
//   out_src    channel that produced out_data
module stream_arb_mux #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 8,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic                    mode,
  input  logic                    force_en,
  input  logic [SEL_W-1:0]        force_sel,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SEL_W-1:0]        out_src
);

  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic [SEL_W-1:0]  out_src_q, out_src_d;
  logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;

  logic [NUM_IN-1:0] elig;
  logic [SEL_W-1:0]  gnt;
  logic              gnt_vld;
  logic              free;
  logic              xfer;
  logic              use_fixed;

  // Channel index reached k steps after ptr, wrapping at NUM_IN.
  function automatic logic [SEL_W-1:0] rr_idx(
    input logic [SEL_W-1:0] ptr,
    input int               k
  );
    int j;
    j = int'(ptr) + k;
    if (j >= NUM_IN) j = j - NUM_IN;
    return SEL_W'(j);
  endfunction

  assign free      = !out_valid_q || out_ready;
  assign use_fixed = mode || force_en;

  // A force_sel outside 0..NUM_IN-1 matches no channel, leaving
  // the eligible set empty.
  always_comb begin
    elig = '0;
    if (force_en) begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (force_sel == SEL_W'(i)) elig[i] = in_valid[i];
      end
    end else begin
      elig = in_valid;
    end
  end

  // Scans run from the far end so the last hit is the winner:
  // lowest index for fixed, nearest to rr_ptr for round-robin.
  always_comb begin
    gnt = '0;
    if (use_fixed) begin
      for (int i = NUM_IN - 1; i >= 0; i--) begin
        if (elig[i]) gnt = SEL_W'(i);
      end
    end else begin
      for (int k = NUM_IN - 1; k >= 0; k--) begin
        if (elig[rr_idx(rr_ptr_q, k)]) gnt = rr_idx(rr_ptr_q, k);
      end
    end
  end

  assign gnt_vld = |elig;
  assign xfer    = gnt_vld && free && !Rst;

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      in_ready[i] = xfer && (gnt == SEL_W'(i));
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    out_valid_d = out_valid_q;
    rr_ptr_d    = rr_ptr_q;
    if (free) out_valid_d = 1'b0;
    if (xfer) begin
      out_data_d  = in_data[int'(gnt)*WIDTH +: WIDTH];
      out_src_d   = gnt;
      out_valid_d = 1'b1;
      if (!use_fixed) begin
        rr_ptr_d = (gnt == SEL_W'(NUM_IN - 1)) ? '0 : gnt + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      out_data_q  <= '0;
      out_src_q   <= '0;
      out_valid_q <= 1'b0;
      rr_ptr_q    <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      out_valid_q <= out_valid_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_src   = out_src_q;

endmodule

// File: tb/tb_stream_arb_mux.sv
// tb_stream_arb_mux: directed self-checking bench for stream_arb_mux
// with NUM_IN=8, WIDTH=32 and channel i carrying 32'hA0+i.
module tb_stream_arb_mux;
  localparam int W  = 32;
  localparam int N  = 8;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [N*W-1:0] in_data;
  logic [N-1:0]  in_valid;
  logic [N-1:0]  in_ready;
  logic          mode;
  logic          force_en;
  logic [SW-1:0] force_sel;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready;
  logic [SW-1:0] out_src;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  stream_arb_mux #(.WIDTH(W), .NUM_IN(N)) dut (
    .Clk(clk),
    .Rst(rst),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .mode(mode),
    .force_en(force_en),
    .force_sel(force_sel),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_src(out_src)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = '1;
    out_ready = 1'b1;
    mode = 1'b0;
    force_en = 1'b0;
    force_sel = '0;
    tick();
    tick();
    nvec++;
    if ({out_valid, out_src, out_data} !== {1'b0, 3'd0, 32'd0}) begin
      $display("FAIL reset_state: got %h want %h",
               {out_valid, out_src, out_data}, {1'b0, 3'd0, 32'd0});
      nerr++;
    end
    nvec++;
    if (in_ready !== 8'h00) begin
      $display("FAIL reset_ready: got %h want 00", in_ready);
      nerr++;
    end
    rst = 1'b0;
    #1;
    nvec++;
    if (in_ready !== 8'h01) begin
      $display("FAIL reset_first_ready: got %h want 01", in_ready);
      nerr++;
    end
    tick();
    nvec++;
    if ({out_valid, out_src, out_data} !== {1'b1, 3'd0, 32'hA0}) begin
      $display("FAIL reset_first_beat: got %h want %h",
               {out_valid, out_src, out_data}, {1'b1, 3'd0, 32'hA0});
      nerr++;
    end
  endtask

  task automatic test_rr_sweep();
    for (int k = 1; k < 16; k++) begin
      logic [SW-1:0] s;
      logic [N-1:0]  er;
      s  = SW'(k % N);
      er = N'(1) << s;
      nvec++;
      if (in_ready !== er) begin
        $display("FAIL rr_ready[%0d]: got %h want %h", k, in_ready, er);
        nerr++;
      end
      tick();
      nvec++;
      if ({out_valid, out_src, out_data} !== {1'b1, s, 32'hA0 + 32'(s)}) begin
        $display("FAIL rr_beat[%0d]: got %h want %h", k,
                 {out_valid, out_src, out_data}, {1'b1, s, 32'hA0 + 32'(s)});
        nerr++;
      end
    end
  endtask

  task automatic test_fixed_priority();
    in_valid = 8'h24;
    #1;
    nvec++;
    if (in_ready !== 8'h04) begin
      $display("FAIL fp_rr_pick2: got %h want 04", in_ready);
      nerr++;
    end
    tick();
    nvec++;
    if ({out_valid, out_src, out_data} !== {1'b1, 3'd2, 32'hA2}) begin
      $display("FAIL fp_rr_beat2: got %h want %h",
               {out_valid, out_src, out_data}, {1'b1, 3'd2, 32'hA2});
      nerr++;
    end
    mode = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      nvec++;
      if (in_ready !== 8'h04) begin
        $display("FAIL fp_ready[%0d]: got %h want 04", k, in_ready);
        nerr++;
      end
      tick();
      nvec++;
      if ({out_valid, out_src, out_data} !== {1'b1, 3'd2, 32'hA2}) begin
        $display("FAIL fp_beat[%0d]: got %h want %h", k,
                 {out_valid, out_src, out_data}, {1'b1, 3'd2, 32'hA2});
        nerr++;
      end
    end
    mode = 1'b0;
    #1;
    nvec++;
    if (in_ready !== 8'h20) begin
      $display("FAIL fp_ptr_hold_ready: got %h want 20", in_ready);
      nerr++;
    end
    tick();
    nvec++;
    if ({out_valid, out_src, out_data} !== {1'b1, 3'd5, 32'hA5}) begin
      $display("FAIL fp_ptr_hold_beat: got %h want %h",
               {out_valid, out_src, out_data}, {1'b1, 3'd5, 32'hA5});
      nerr++;
    end
  endtask

  task automatic test_forced_select();
    in_valid = '1;
    force_en = 1'b1;
    force_sel = 3'd6;
    mode = 1'b1;
    #1;
    nvec++;
    if (in_ready !== 8'h40) begin
      $display("FAIL force_over_mode: got %h want 40", in_ready);
      nerr++;
    end
    mode = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      nvec++;
      if (in_ready !== 8'h40) begin
        $display("FAIL force_ready[%0d]: got %h want 40", k, in_ready);
        nerr++;
      end
      tick();
      nvec++;
      if ({out_valid, out_src, out_data} !== {1'b1, 3'd6, 32'hA6}) begin
        $display("FAIL force_beat[%0d]: got %h want %h", k,
                 {out_valid, out_src, out_data}, {1'b1, 3'd6, 32'hA6});
        nerr++;
      end
    end
    in_valid = 8'hBF;
    #1;
    nvec++;
    if (in_ready !== 8'h00) begin
      $display("FAIL force_idle_ready: got %h want 00", in_ready);
      nerr++;
    end
    tick();
    nvec++;
    if ({out_valid, out_src, out_data} !== {1'b0, 3'd6, 32'hA6}) begin
      $display("FAIL force_drain: got %h want %h",
               {out_valid, out_src, out_data}, {1'b0, 3'd6, 32'hA6});
      nerr++;
    end
    force_en = 1'b0;
    in_valid = '1;
    #1;
    nvec++;
    if (in_ready !== 8'h40) begin
      $display("FAIL force_ptr_hold: got %h want 40", in_ready);
      nerr++;
    end
    tick();
    nvec++;
    if ({out_valid, out_src, out_data} !== {1'b1, 3'd6, 32'hA6}) begin
      $display("FAIL force_release_beat: got %h want %h",
               {out_valid, out_src, out_data}, {1'b1, 3'd6, 32'hA6});
      nerr++;
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    #1;
    nvec++;
    if (in_ready !== 8'h00) begin
      $display("FAIL bp_ready_low: got %h want 00", in_ready);
      nerr++;
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      nvec++;
      if ({out_valid, out_src, out_data, in_ready} !==
          {1'b1, 3'd6, 32'hA6, 8'h00}) begin
        $display("FAIL bp_hold[%0d]: got %h want %h", k,
                 {out_valid, out_src, out_data, in_ready},
                 {1'b1, 3'd6, 32'hA6, 8'h00});
        nerr++;
      end
    end
    out_ready = 1'b1;
    #1;
    nvec++;
    if (in_ready !== 8'h80) begin
      $display("FAIL bp_release_ready: got %h want 80", in_ready);
      nerr++;
    end
    tick();
    nvec++;
    if ({out_valid, out_src, out_data} !== {1'b1, 3'd7, 32'hA7}) begin
      $display("FAIL bp_release_beat: got %h want %h",
               {out_valid, out_src, out_data}, {1'b1, 3'd7, 32'hA7});
      nerr++;
    end
  endtask

  task automatic test_reset_mid_stall();
    tick();
    nvec++;
    if ({out_valid, out_src, out_data} !== {1'b1, 3'd0, 32'hA0}) begin
      $display("FAIL rst_pre_beat: got %h want %h",
               {out_valid, out_src, out_data}, {1'b1, 3'd0, 32'hA0});
      nerr++;
    end
    out_ready = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    nvec++;
    if (in_ready !== 8'h00) begin
      $display("FAIL rst_mid_ready: got %h want 00", in_ready);
      nerr++;
    end
    tick();
    rst = 1'b0;
    #1;
    nvec++;
    if ({out_valid, out_src, out_data} !== {1'b0, 3'd0, 32'd0}) begin
      $display("FAIL rst_mid_state: got %h want %h",
               {out_valid, out_src, out_data}, {1'b0, 3'd0, 32'd0});
      nerr++;
    end
    nvec++;
    if (in_ready !== 8'h01) begin
      $display("FAIL rst_mid_ptr: got %h want 01", in_ready);
      nerr++;
    end
    out_ready = 1'b1;
    tick();
    nvec++;
    if ({out_valid, out_src, out_data} !== {1'b1, 3'd0, 32'hA0}) begin
      $display("FAIL rst_mid_after: got %h want %h",
               {out_valid, out_src, out_data}, {1'b1, 3'd0, 32'hA0});
      nerr++;
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) in_data[i*W +: W] = 32'hA0 + 32'(i);
    rst = 1'b1;
    in_valid = '0;
    out_ready = 1'b0;
    mode = 1'b0;
    force_en = 1'b0;
    force_sel = '0;
    test_reset();
    test_rr_sweep();
    test_fixed_priority();
    test_forced_select();
    test_backpressure();
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end

endmodule
